// File: rtl/du_load_run_ctrl.sv
// Debug-unit sequencer: loads a program from UART into instruction memory, runs the
// pipeline continuously or step-by-step, and dumps PC, cycle count, registers and data memory.
module du_load_run_ctrl #(
    parameter int          NB_DATA     = 32,
    parameter int          ADDRWIDTH   = 7,
    parameter int          N_REGISTER  = 32,
    parameter int          N_MEM_WORDS = 32,
    parameter logic [7:0]  MODE_STEP   = 8'h0F,
    parameter logic [7:0]  MODE_CONT   = 8'hF0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic [7:0]           tx_data_o,
    output logic                 tx_start_o,
    input  logic                 tx_done_i,
    output logic                 imem_wr_en_o,
    output logic [ADDRWIDTH-1:0] imem_addr_o,
    output logic [NB_DATA-1:0]   imem_data_o,
    output logic                 clock_proc_o,
    input  logic                 halt_i,
    output logic [4:0]           reg_addr_o,
    input  logic [NB_DATA-1:0]   reg_data_i,
    output logic [ADDRWIDTH-1:0] mem_addr_o,
    input  logic [NB_DATA-1:0]   mem_data_i,
    input  logic [NB_DATA-1:0]   pc_i,
    output logic                 ack_debug_o,
    output logic                 end_send_data_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RX   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_STEP = 3'd4;
    localparam logic [2:0] S_DUMP = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    localparam logic [1:0] D_ADDR  = 2'd0;
    localparam logic [1:0] D_LATCH = 2'd1;
    localparam logic [1:0] D_SEND  = 2'd2;
    localparam logic [1:0] D_WAIT  = 2'd3;

    // Dump items: 0 = PC, 1 = cycle count, then registers, then memory words.
    localparam logic [7:0] REG_FIRST = 8'd2;
    localparam logic [7:0] MEM_FIRST = 8'(2 + N_REGISTER);
    localparam logic [7:0] LAST_ITEM = 8'(2 + N_REGISTER + N_MEM_WORDS - 1);

    logic [2:0]           state_q, state_d;
    logic [1:0]           dphase_q, dphase_d;
    logic [7:0]           n_q, n_d;
    logic [7:0]           inst_cnt_q, inst_cnt_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [7:0]           cycle_cnt_q, cycle_cnt_d;
    logic [7:0]           item_q, item_d;
    logic [NB_DATA-1:0]   word_q, word_d;
    logic [NB_DATA-1:0]   shift_q, shift_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDRWIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [NB_DATA-1:0]   imem_data_q, imem_data_d;
    logic                 clk_en_q, clk_en_d;
    logic                 final_q, final_d;

    logic                 in_regs, in_mem;
    logic [7:0]           reg_idx, mem_idx;
    logic [1:0]           last_byte;
    logic [NB_DATA-1:0]   load_word;

    assign in_regs   = (item_q >= REG_FIRST) && (item_q < MEM_FIRST);
    assign in_mem    = (item_q >= MEM_FIRST);
    assign reg_idx   = item_q - REG_FIRST;
    assign mem_idx   = item_q - MEM_FIRST;
    assign last_byte = (item_q == 8'd1) ? 2'd0 : 2'd3;

    always_comb begin
        if (item_q == 8'd0)
            load_word = pc_i;
        else if (item_q == 8'd1)
            load_word = {{(NB_DATA-8){1'b0}}, cycle_cnt_q};
        else if (in_regs)
            load_word = reg_data_i;
        else
            load_word = mem_data_i;
    end

    always_comb begin
        state_d     = state_q;
        dphase_d    = dphase_q;
        n_d         = n_q;
        inst_cnt_d  = inst_cnt_q;
        byte_idx_d  = byte_idx_q;
        cycle_cnt_d = cycle_cnt_q + {7'd0, clk_en_q};
        item_d      = item_q;
        word_d      = word_q;
        shift_d     = shift_q;
        wr_en_d     = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        clk_en_d    = 1'b0;
        final_d     = final_q;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    n_d        = rx_data_i;
                    inst_cnt_d = 8'd0;
                    byte_idx_d = 2'd0;
                    state_d    = (rx_data_i == 8'd0) ? S_WAIT : S_RX;
                end
            end
            S_RX: begin
                if (rx_valid_i) begin
                    word_d     = {rx_data_i, word_q[NB_DATA-1:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d     = 1'b1;
                        imem_addr_d = inst_cnt_q[ADDRWIDTH-1:0];
                        imem_data_d = word_d;
                        inst_cnt_d  = inst_cnt_q + 8'd1;
                        if (inst_cnt_q == n_q - 8'd1)
                            state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (rx_valid_i && rx_data_i == MODE_CONT) begin
                    state_d  = S_RUN;
                    clk_en_d = !halt_i;
                end else if (rx_valid_i && rx_data_i == MODE_STEP) begin
                    state_d  = S_STEP;
                    clk_en_d = !halt_i;
                end
            end
            S_RUN: begin
                // Enable is registered, so it drops the cycle after halt is observed.
                if (halt_i) begin
                    state_d    = S_DUMP;
                    final_d    = 1'b1;
                    item_d     = 8'd0;
                    byte_idx_d = 2'd0;
                    dphase_d   = D_ADDR;
                end else begin
                    clk_en_d = 1'b1;
                end
            end
            S_STEP: begin
                state_d    = S_DUMP;
                final_d    = halt_i;
                item_d     = 8'd0;
                byte_idx_d = 2'd0;
                dphase_d   = D_ADDR;
            end
            S_DUMP: begin
                case (dphase_q)
                    D_ADDR:  dphase_d = D_LATCH;
                    D_LATCH: begin
                        shift_d  = load_word;
                        dphase_d = D_SEND;
                    end
                    D_SEND:  dphase_d = D_WAIT;
                    default: begin
                        if (tx_done_i) begin
                            if (byte_idx_q == last_byte) begin
                                byte_idx_d = 2'd0;
                                if (item_q == LAST_ITEM) begin
                                    state_d = final_q ? S_DONE : S_WAIT;
                                end else begin
                                    item_d   = item_q + 8'd1;
                                    dphase_d = D_ADDR;
                                end
                            end else begin
                                byte_idx_d = byte_idx_q + 2'd1;
                                shift_d    = shift_q >> 8;
                                dphase_d   = D_SEND;
                            end
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            dphase_q    <= D_ADDR;
            n_q         <= '0;
            inst_cnt_q  <= '0;
            byte_idx_q  <= '0;
            cycle_cnt_q <= '0;
            item_q      <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            wr_en_q     <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            clk_en_q    <= 1'b0;
            final_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dphase_q    <= dphase_d;
            n_q         <= n_d;
            inst_cnt_q  <= inst_cnt_d;
            byte_idx_q  <= byte_idx_d;
            cycle_cnt_q <= cycle_cnt_d;
            item_q      <= item_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            wr_en_q     <= wr_en_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            clk_en_q    <= clk_en_d;
            final_q     <= final_d;
        end
    end

    assign tx_data_o       = shift_q[7:0];
    assign tx_start_o      = (state_q == S_DUMP) && (dphase_q == D_SEND);
    assign imem_wr_en_o    = wr_en_q;
    assign imem_addr_o     = imem_addr_q;
    assign imem_data_o     = imem_data_q;
    assign clock_proc_o    = clk_en_q;
    assign reg_addr_o      = (state_q == S_DUMP && in_regs) ? reg_idx[4:0] : 5'd0;
    assign mem_addr_o      = (state_q == S_DUMP && in_mem) ? mem_idx[ADDRWIDTH-1:0] : '0;
    assign ack_debug_o     = (state_q == S_WAIT);
    assign end_send_data_o = (state_q == S_DONE);

endmodule
